// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the memory access unit.
// Holds bus widths, region base addresses, the access FSM state encoding
// and the one-hot region select payload.
package arch_defs_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned CNT_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] ROM_BASE  = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] RAM_BASE  = 16'h8000;
  localparam logic [ADDR_WIDTH-1:0] MMIO_BASE = 16'hF000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // One-hot region select; exactly one field is set for any address.
  typedef struct packed {
    logic rom;
    logic ram;
    logic io;
  } region_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-to-region decoder.
// Ports:
//   addr_i      - address to classify
//   region_o_c  - one-hot region select (rom / ram / io), combinational
module mem_region_decode
  import arch_defs_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output region_t               region_o_c
);

  // Regions are contiguous and ascending, so compare from the top down.
  always_comb begin
    region_o_c = '0;
    if (addr_i >= MMIO_BASE) begin
      region_o_c.io = 1'b1;
    end else if (addr_i >= RAM_BASE) begin
      region_o_c.ram = 1'b1;
    end else begin
      region_o_c.rom = 1'b1;
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory access unit: accepts a single read or write request, decodes the
// latched address into ROM / RAM / MMIO, drives the region chip select for
// the region-specific number of cycles and reports completion.
// Ports:
//   clk, reset                        - clock, async active-high reset
//   address_in, data_in               - request address / write data
//   req_read, req_write               - request strobes (sampled in IDLE)
//   rom_rdata, ram_rdata, io_rdata    - region read data
//   io_ready                          - MMIO completion
//   mem_addr, mem_wdata               - latched address / write data
//   rom_cs, ram_cs, io_cs, mem_we     - region selects and write strobe
//   data_out                          - last completed read result
//   busy, done, bus_error             - status
module memory_access_unit
  import arch_defs_pkg::*;
#(
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic [DATA_WIDTH-1:0] io_rdata,
  input  logic                  io_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rom_cs,
  output logic                  ram_cs,
  output logic                  io_cs,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_error
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic                  err_q, err_d;
  region_t               region_q, region_d;
  logic                  rom_cs_q, rom_cs_d, ram_cs_q, ram_cs_d;
  logic                  io_cs_q, io_cs_d, we_q, we_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  req_one, req_both, io_timeout, rom_wait_last, active;

  assign req_one       = req_read ^ req_write;
  assign req_both      = req_read & req_write;
  assign io_timeout    = (cnt_q == CNT_WIDTH'(IO_TIMEOUT - 1));
  assign rom_wait_last = (cnt_q == CNT_WIDTH'(ROM_WAIT - 1));

  // Decode the next latched address so registered selects line up with state.
  mem_region_decode u_decode (
    .addr_i     (addr_d),
    .region_o_c (region_d)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_one) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (region_q.io) begin
          // io_ready takes priority over a simultaneous timeout
          if (io_ready)        state_d = is_write_q ? ST_DONE : ST_CAPTURE;
          else if (io_timeout) state_d = ST_DONE;
        end else if (is_write_q) begin
          state_d = ST_DONE;
        end else if (region_q.rom && (ROM_WAIT != 0)) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_WAIT:    if (rom_wait_last) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: request latch, cycle counter, error flag, read data
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_one) begin
          addr_d     = address_in;
          wdata_d    = data_in;
          is_write_d = req_write;
          err_d      = 1'b0;
          cnt_d      = '0;
        end else if (req_both) begin
          err_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (region_q.io) begin
          if (!io_ready && io_timeout) begin
            err_d  = 1'b1;
            dout_d = '1;
          end
        end else if (region_q.rom) begin
          // Counter is reused to pace the ROM wait cycles
          cnt_d = '0;
          if (is_write_q) err_d = 1'b1;
        end
      end
      ST_WAIT:    cnt_d = cnt_q + CNT_WIDTH'(1);
      ST_CAPTURE: dout_d = region_q.io  ? io_rdata  :
                           region_q.ram ? ram_rdata : rom_rdata;
      default: ;
    endcase
  end

  // Output logic, computed from the next state so the outputs are registered
  always_comb begin
    active   = (state_d == ST_ACCESS) || (state_d == ST_WAIT);
    rom_cs_d = active && region_d.rom && !is_write_d;
    ram_cs_d = active && region_d.ram;
    io_cs_d  = active && region_d.io;
    we_d     = active && is_write_d && !region_d.rom;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      region_q   <= '0;
      rom_cs_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      io_cs_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      region_q   <= region_d;
      rom_cs_q   <= rom_cs_d;
      ram_cs_q   <= ram_cs_d;
      io_cs_q    <= io_cs_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rom_cs    = rom_cs_q;
  assign ram_cs    = ram_cs_q;
  assign io_cs     = io_cs_q;
  assign mem_we    = we_q;
  assign data_out  = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bus_error = err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed testbench for memory_access_unit (ROM_WAIT=2, IO_TIMEOUT=15).
// A small synchronous RAM model and a programmable-latency MMIO responder
// sit next to the DUT; the latency counts below include the request edge.
module tb_memory_access_unit;
  import arch_defs_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [ADDR_WIDTH-1:0] address_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  req_read, req_write;
  logic [DATA_WIDTH-1:0] rom_rdata, ram_rdata, io_rdata;
  logic                  io_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rom_cs, ram_cs, io_cs, mem_we;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy, done, bus_error;

  int tests = 0;
  int failed = 0;
  int rom_n, ram_n, io_n, we_n;
  int n;
  int io_cyc = 0;
  int io_delay = 0;
  logic io_en = 1'b0;
  logic [DATA_WIDTH-1:0] ram_mem [256];

  memory_access_unit #(.ROM_WAIT(2), .IO_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .data_in(data_in),
    .req_read(req_read), .req_write(req_write), .rom_rdata(rom_rdata),
    .ram_rdata(ram_rdata), .io_rdata(io_rdata), .io_ready(io_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rom_cs(rom_cs),
    .ram_cs(ram_cs), .io_cs(io_cs), .mem_we(mem_we), .data_out(data_out),
    .busy(busy), .done(done), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write and registered read while selected
  always @(posedge clk) begin
    if (ram_cs) begin
      if (mem_we) ram_mem[mem_addr[7:0]] <= mem_wdata;
      ram_rdata <= ram_mem[mem_addr[7:0]];
    end
  end

  // MMIO responder: ready after io_delay cycles of io_cs
  always @(posedge clk) begin
    if (io_cs) io_cyc <= io_cyc + 1;
    else       io_cyc <= 0;
  end
  assign io_ready = io_cs && io_en && (io_cyc == io_delay);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and run until done (or max edges); count strobe cycles
  task automatic access(input logic rd, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d, input int max, output int lat);
    req_read = rd; req_write = wr; address_in = a; data_in = d;
    lat = 0; rom_n = 0; ram_n = 0; io_n = 0; we_n = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        req_read = 1'b0; req_write = 1'b0;
        address_in = ~a; data_in = ~d;
      end
      if (rom_cs) rom_n++;
      if (ram_cs) ram_n++;
      if (io_cs)  io_n++;
      if (mem_we) we_n++;
    end while (done !== 1'b1 && lat < max);
  endtask

  initial begin
    reset = 1'b1; address_in = '0; data_in = '0;
    req_read = 1'b0; req_write = 1'b0;
    rom_rdata = 8'hC3; io_rdata = 8'h7E;
    repeat (2) tick();
    check("rst_cs", 32'({rom_cs, ram_cs, io_cs, mem_we}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(bus_error), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    reset = 1'b0;

    // RAM write, accepted on the first edge after reset release
    access(1'b0, 1'b1, 16'h8010, 8'h5A, 20, n);
    check("ramw_lat", 32'(n), 2);
    check("ramw_cs", 32'(ram_n), 1);
    check("ramw_we", 32'(we_n), 1);
    check("ramw_wdata", 32'(mem_wdata), 32'h5A);
    check("ramw_err", 32'(bus_error), 0);
    tick();

    access(1'b1, 1'b0, 16'h8010, 8'h00, 20, n);
    check("ramr_lat", 32'(n), 3);
    check("ramr_dout", 32'(data_out), 32'h5A);
    check("ramr_we", 32'(we_n), 0);
    check("ramr_addr", 32'(mem_addr), 32'h8010);
    tick();

    access(1'b1, 1'b0, ROM_BASE + 16'h0004, 8'h00, 20, n);
    check("romr_lat", 32'(n), 5);
    check("romr_cs", 32'(rom_n), 3);
    check("romr_dout", 32'(data_out), 32'hC3);
    check("romr_err", 32'(bus_error), 0);
    tick();

    access(1'b0, 1'b1, 16'h0100, 8'h11, 20, n);
    check("romw_lat", 32'(n), 2);
    check("romw_cs", 32'(rom_n), 0);
    check("romw_we", 32'(we_n), 0);
    check("romw_err", 32'(bus_error), 1);
    check("romw_dout", 32'(data_out), 32'hC3);
    tick();
    check("err_sticky", 32'(bus_error), 1);
    check("idle_busy", 32'(busy), 0);

    io_en = 1'b1; io_delay = 3;
    access(1'b1, 1'b0, 16'hF002, 8'h00, 30, n);
    check("ior_lat", 32'(n), 6);
    check("ior_cs", 32'(io_n), 4);
    check("ior_dout", 32'(data_out), 32'h7E);
    check("ior_err", 32'(bus_error), 0);
    tick();

    io_en = 1'b0;
    access(1'b1, 1'b0, 16'hF002, 8'h00, 30, n);
    check("iot_lat", 32'(n), 16);
    check("iot_cs", 32'(io_n), 15);
    check("iot_err", 32'(bus_error), 1);
    check("iot_dout", 32'(data_out), 32'hFF);
    tick();

    // io_ready on the same edge as the timeout
    io_en = 1'b1; io_delay = 14;
    access(1'b1, 1'b0, 16'hF002, 8'h00, 30, n);
    check("iob_lat", 32'(n), 17);
    check("iob_err", 32'(bus_error), 0);
    check("iob_dout", 32'(data_out), 32'h7E);
    tick();

    io_delay = 0;
    access(1'b0, 1'b1, 16'hF010, 8'h99, 20, n);
    check("iow_lat", 32'(n), 2);
    check("iow_we", 32'(we_n), 1);
    check("iow_wdata", 32'(mem_wdata), 32'h99);
    check("iow_dout", 32'(data_out), 32'h7E);
    // request presented during DONE must not be taken
    req_read = 1'b1; address_in = 16'h8010;
    tick();
    req_read = 1'b0;
    check("done_noacc", 32'(busy), 0);

    // both strobes together: ignored with error
    req_read = 1'b1; req_write = 1'b1; address_in = 16'h8000;
    tick();
    req_read = 1'b0; req_write = 1'b0;
    check("both_cs", 32'({rom_cs, ram_cs, io_cs, mem_we}), 0);
    check("both_busy", 32'(busy), 0);
    check("both_err", 32'(bus_error), 1);
    tick();
    check("both_idle", 32'(busy), 0);

    // reset asserted during ROM WAIT
    req_read = 1'b1; address_in = 16'h0004;
    tick();
    req_read = 1'b0;
    tick();
    check("wait_cs", 32'(rom_cs), 1);
    reset = 1'b1;
    #1;
    check("mid_cs", 32'({rom_cs, ram_cs, io_cs, mem_we}), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_err", 32'(bus_error), 0);
    check("mid_dout", 32'(data_out), 0);
    check("mid_addr", 32'(mem_addr), 0);
    tick();
    reset = 1'b0;

    access(1'b1, 1'b0, 16'h8010, 8'h00, 20, n);
    check("post_lat", 32'(n), 3);
    check("post_dout", 32'(data_out), 32'h5A);
    check("post_err", 32'(bus_error), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter ROM_WAIT, default 1, extra wait cycles for ROM reads (0..7).
REQ-002 Parameter IO_TIMEOUT, default 15, max MMIO wait cycles before bus error (1..255).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 address_in  in  ADDR_WIDTH  address from memory address register.
REQ-006 data_in  in  DATA_WIDTH  write data from CPU bus.
REQ-007 req_read / req_write  in  1 each  access request, sampled only in IDLE.
REQ-008 rom_rdata, ram_rdata, io_rdata  in  DATA_WIDTH each  region read data.
REQ-009 io_ready  in  1  MMIO device completion.
REQ-010 mem_addr  out  ADDR_WIDTH, mem_wdata  out  DATA_WIDTH  latched address and write data.
REQ-011 rom_cs, ram_cs, io_cs, mem_we  out  1 each  region selects and write strobe.
REQ-012 data_out  out  DATA_WIDTH  registered read result.
REQ-013 busy, done, bus_error  out  1 each  status.

Function
REQ-014 Region decode on latched address: ROM 0x0000-0x7FFF, RAM 0x8000-0xEFFF, MMIO 0xF000-0xFFFF.
REQ-015 FSM states IDLE, ACCESS, WAIT, CAPTURE, DONE; busy = 1 in every state except IDLE.
REQ-016 IDLE: on edge with exactly one of req_read/req_write high, latch address_in, data_in, direction; clear bus_error; go ACCESS.
REQ-017 IDLE: req_read and req_write both high -> request ignored, bus_error set, remain IDLE.
REQ-018 ACCESS/WAIT: selected cs high; mem_we high only for writes; all cs and mem_we low in IDLE, CAPTURE, DONE.
REQ-019 RAM: ACCESS 1 cycle; read -> CAPTURE; write -> DONE.
REQ-020 ROM read: ACCESS then ROM_WAIT WAIT cycles (cs held), then CAPTURE; ROM_WAIT=0 skips WAIT.
REQ-021 ROM write: no cs, no mem_we asserted; bus_error set; ACCESS -> DONE; ROM contents untouched.
REQ-022 MMIO: remain in ACCESS with io_cs held until io_ready sampled high, then read -> CAPTURE, write -> DONE.
REQ-023 MMIO timeout: 8-bit counter reset on ACCESS entry; io_ready still low after IO_TIMEOUT ACCESS cycles -> bus_error set, data_out = 0xFF, go DONE.
REQ-024 io_ready and timeout on same edge: io_ready wins, no error.
REQ-025 CAPTURE: data_out <= rdata of latched region on exit edge; go DONE.
REQ-026 DONE: done = 1 for exactly one cycle; return IDLE; new requests not accepted in DONE.
REQ-027 data_out holds value until next completed read; writes do not change it.
REQ-028 bus_error sticky until next accepted request or reset.
REQ-029 Latency request edge -> done high: RAM read 3 cycles, RAM write 2, ROM read 3+ROM_WAIT, MMIO read 3+wait cycles.
REQ-030 address_in/data_in changes after acceptance have no effect on the access in progress.

Reset
REQ-031 reset asserted at any time, including mid-access: FSM -> IDLE immediately, all cs/mem_we/busy/done/bus_error = 0, data_out = 0x00, mem_addr = 0x0000, mem_wdata = 0x00, counters = 0.
REQ-032 First request accepted on first clock edge after reset deasserts.

Structure
REQ-033 Region base constants (ROM_BASE, RAM_BASE, MMIO_BASE) and FSM state enum reside in arch_defs_pkg; DATA_WIDTH/ADDR_WIDTH taken from it.
REQ-034 One sub-module, mem_region_decode: combinational address -> one-hot region select.

Verification
REQ-035 RAM write 0x8010<-0x5A then read 0x8010 (ram model sync) -> write done cycle 2, read done cycle 3, data_out=0x5A, bus_error=0.
REQ-036 ROM read 0x0004 with ROM_WAIT=2, rom_rdata=0xC3 -> rom_cs high 3 cycles, done at cycle 5, data_out=0xC3.
REQ-037 ROM write 0x0100 <- 0x11 -> rom_cs and mem_we never high, bus_error=1, done pulses, data_out unchanged.
REQ-038 MMIO read 0xF002, io_ready after 4 cycles, io_rdata=0x7E -> data_out=0x7E, no error; repeat with io_ready never high -> after 15 cycles bus_error=1, data_out=0xFF.
REQ-039 Assert reset during ROM WAIT -> all outputs at reset values same cycle; next RAM read completes normally.
REQ-040 req_read and req_write both high in IDLE -> no cs asserted, bus_error=1, busy=0.
